// File: rtl/gain_sched_ctrl.sv
// gain_sched_ctrl
//   Gain update scheduler. Host gain words written over CtrlPort are queued
//   in a small FIFO and applied to gain_active only at payload packet
//   boundaries, so every packet is scaled by one constant gain.
//
// Ports
//   axis_data_clk / axis_data_rst : sole clock, synchronous active-high reset
//   s_ctrlport_req_*              : CtrlPort request (wr/rd strobes, addr, data)
//   s_ctrlport_resp_ack/_data     : registered response, one cycle after request
//   pkt_tvalid/_tready/_tlast     : observed payload stream handshake (monitor)
//   gain_active                   : gain applied to the current payload beat
//
// Register map (byte offsets from BASE_ADDR)
//   0x00 GAIN_PUSH (W)   0x04 GAIN_ACTIVE (R)   0x08 STATUS (R/W1C)
//   0x0C CTRL (W)        0x10 PKT_COUNT (R/W, any write clears)
module gain_sched_ctrl #(
  parameter int              GAIN_W       = 16,
  parameter logic [GAIN_W-1:0] DEFAULT_GAIN = 16'h0100,
  parameter int              FIFO_AW      = 2,
  parameter logic [19:0]     BASE_ADDR    = 20'h0
) (
  input  logic              axis_data_clk,
  input  logic              axis_data_rst,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic              pkt_tvalid,
  input  logic              pkt_tready,
  input  logic              pkt_tlast,
  output logic [GAIN_W-1:0] gain_active
);

  localparam int          DEPTH       = 1 << FIFO_AW;
  localparam logic [19:0] ADDR_PUSH   = BASE_ADDR + 20'h00;
  localparam logic [19:0] ADDR_ACTIVE = BASE_ADDR + 20'h04;
  localparam logic [19:0] ADDR_STATUS = BASE_ADDR + 20'h08;
  localparam logic [19:0] ADDR_CTRL   = BASE_ADDR + 20'h0C;
  localparam logic [19:0] ADDR_COUNT  = BASE_ADDR + 20'h10;

  logic [GAIN_W-1:0]  fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fill;
  logic               overflow;
  logic               in_pkt;
  logic [31:0]        pkt_count;

  logic        accept;
  logic        boundary;
  logic        pop;
  logic        full;
  logic        wr_req;
  logic        rd_req;
  logic        push_req;
  logic        push_ok;
  logic        ovf_set;
  logic        ovf_clr;
  logic        flush;
  logic        cnt_clr;
  logic [31:0] status;
  logic [31:0] rd_data;

  // Only a few write-data bits are decoded; fold the rest so they are not
  // reported as dangling.
  logic unused_req_data;
  assign unused_req_data = ^s_ctrlport_req_data;

  always_comb begin
    accept   = pkt_tvalid & pkt_tready;
    // Between packets every idle cycle is a pop opportunity; inside a packet
    // only the tlast beat is.
    boundary = (accept & pkt_tlast) | (~in_pkt & ~accept);
    pop      = boundary & (fill != '0);
    full     = (fill == (FIFO_AW+1)'(DEPTH));

    // Simultaneous wr+rd is handled as a write only.
    wr_req   = s_ctrlport_req_wr;
    rd_req   = s_ctrlport_req_rd & ~s_ctrlport_req_wr;

    push_req = wr_req & (s_ctrlport_req_addr == ADDR_PUSH);
    push_ok  = push_req & (~full | pop);
    ovf_set  = push_req & full & ~pop;
    ovf_clr  = wr_req & (s_ctrlport_req_addr == ADDR_STATUS) & s_ctrlport_req_data[8];
    flush    = wr_req & (s_ctrlport_req_addr == ADDR_CTRL) & s_ctrlport_req_data[0];
    cnt_clr  = wr_req & (s_ctrlport_req_addr == ADDR_COUNT);

    status            = '0;
    status[FIFO_AW:0] = fill;
    status[8]         = overflow;
    status[9]         = in_pkt;

    rd_data = '0;
    case (s_ctrlport_req_addr)
      ADDR_ACTIVE: rd_data = 32'(gain_active);
      ADDR_STATUS: rd_data = status;
      ADDR_COUNT:  rd_data = pkt_count;
      default:     rd_data = '0;
    endcase
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge axis_data_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= s_ctrlport_req_data[GAIN_W-1:0];
  end

  // Control state, gain register and CtrlPort response stage
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      in_pkt               <= 1'b0;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fill                 <= '0;
      overflow             <= 1'b0;
      pkt_count            <= '0;
      gain_active          <= DEFAULT_GAIN;
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
    end else begin
      if (accept) in_pkt <= ~pkt_tlast;

      if (pop) gain_active <= fifo_mem[rd_ptr];

      // A flush never coincides with a push (one request per cycle); the
      // head popped this cycle is still applied above.
      if (flush) begin
        rd_ptr <= wr_ptr;
        fill   <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
        fill <= fill + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
      end

      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      // Clear wins over a coincident tlast increment.
      if (cnt_clr)                  pkt_count <= '0;
      else if (accept & pkt_tlast)  pkt_count <= pkt_count + 32'd1;

      s_ctrlport_resp_ack  <= wr_req | rd_req;
      s_ctrlport_resp_data <= rd_req ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_gain_sched_ctrl.sv
// tb_gain_sched_ctrl
//   Directed bench for gain_sched_ctrl: CtrlPort accesses interleaved with a
//   driven payload stream; all expected values are hand-computed constants.
module tb_gain_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        tvalid = 1'b0;
  logic        tready = 1'b0;
  logic        tlast = 1'b0;
  logic [15:0] gain_active;

  int n_chk  = 0;
  int n_pass = 0;

  gain_sched_ctrl #(
    .GAIN_W(16), .DEFAULT_GAIN(16'h0100), .FIFO_AW(2), .BASE_ADDR(20'h0)
  ) dut (
    .axis_data_clk        (clk),
    .axis_data_rst        (rst),
    .s_ctrlport_req_wr    (req_wr),
    .s_ctrlport_req_rd    (req_rd),
    .s_ctrlport_req_addr  (req_addr),
    .s_ctrlport_req_data  (req_data),
    .s_ctrlport_resp_ack  (resp_ack),
    .s_ctrlport_resp_data (resp_data),
    .pkt_tvalid           (tvalid),
    .pkt_tready           (tready),
    .pkt_tlast            (tlast),
    .gain_active          (gain_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One CtrlPort request for one cycle; checks the ack and response data.
  task automatic ctrl(input string tag, input logic wr, input logic rd,
                      input logic [19:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata);
    req_wr = wr; req_rd = rd; req_addr = addr; req_data = wdata;
    tick();
    check_val({tag, " ack"}, 32'(resp_ack), 32'd1);
    check_val(tag, resp_data, exp_rdata);
    req_wr = 1'b0; req_rd = 1'b0;
  endtask

  task automatic idle();
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
  endtask

  // Packet of n beats with random back-pressure.
  task automatic send_pkt(input int n);
    for (int b = 0; b < n; b++) begin
      int guard = 0;
      logic acc;
      tvalid = 1'b1;
      tlast  = (b == n - 1);
      do begin
        tready = (guard >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        acc    = tready;
        tick();
        guard++;
      end while (!acc);
    end
    idle();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_val("rst ack", 32'(resp_ack), 32'd0);
    check_val("rst resp_data", resp_data, 32'd0);
    check_val("rst gain", 32'(gain_active), 32'h100);
    rst = 1'b0;
    tick();

    // Read GAIN_ACTIVE, ack is a single-cycle pulse one cycle after request
    req_rd = 1'b1; req_addr = 20'h04;
    check_val("ack before edge", 32'(resp_ack), 32'd0);
    tick();
    check_val("rd active ack", 32'(resp_ack), 32'd1);
    check_val("rd active", resp_data, 32'h100);
    req_rd = 1'b0;
    tick();
    check_val("ack pulse end", 32'(resp_ack), 32'd0);
    check_val("resp_data idle", resp_data, 32'd0);

    // Idle push: applied two cycles after the request
    ctrl("push 200", 1'b1, 1'b0, 20'h00, 32'h0200, 32'd0);
    check_val("gain N+1", 32'(gain_active), 32'h100);
    tick();
    check_val("gain N+2", 32'(gain_active), 32'h200);
    ctrl("status empty", 1'b0, 1'b1, 20'h08, 32'd0, 32'd0);

    // Push mid-packet: held until after the tlast beat
    tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    tick();
    ctrl("push 300", 1'b1, 1'b0, 20'h00, 32'h0300, 32'd0);
    check_val("mid gain a", 32'(gain_active), 32'h200);
    ctrl("status inpkt", 1'b0, 1'b1, 20'h08, 32'd0, 32'h201);
    check_val("mid gain b", 32'(gain_active), 32'h200);
    tlast = 1'b1;
    check_val("tlast beat gain", 32'(gain_active), 32'h200);
    tick();
    tlast = 1'b0;
    check_val("next pkt first beat", 32'(gain_active), 32'h300);
    tick();
    tlast = 1'b1;
    tick();
    idle();

    // Overflow with a stalled packet
    tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    tick();
    tready = 1'b0;
    for (int i = 0; i < 5; i++)
      ctrl("push ovf", 1'b1, 1'b0, 20'h00, 32'h0401 + 32'(i), 32'd0);
    ctrl("status full", 1'b0, 1'b1, 20'h08, 32'd0, 32'h304);
    ctrl("w1c ovf", 1'b1, 1'b0, 20'h08, 32'h100, 32'd0);
    ctrl("status cleared", 1'b0, 1'b1, 20'h08, 32'd0, 32'h204);
    check_val("stall gain", 32'(gain_active), 32'h300);
    for (int i = 0; i < 4; i++) begin
      tready = 1'b1; tlast = 1'b1;
      tick();
      check_val("drain gain", 32'(gain_active), 32'h401 + 32'(i));
    end
    idle();
    tick();
    check_val("dropped 5th", 32'(gain_active), 32'h404);

    // Flush mid-packet
    tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    tick();
    for (int i = 0; i < 3; i++)
      ctrl("push flush", 1'b1, 1'b0, 20'h00, 32'h0501 + 32'(i), 32'd0);
    ctrl("status 3", 1'b0, 1'b1, 20'h08, 32'd0, 32'h203);
    ctrl("flush", 1'b1, 1'b0, 20'h0C, 32'h1, 32'd0);
    ctrl("status flushed", 1'b0, 1'b1, 20'h08, 32'd0, 32'h200);
    tlast = 1'b1;
    tick();
    idle();
    check_val("gain after flush", 32'(gain_active), 32'h404);
    tick();
    check_val("gain after flush idle", 32'(gain_active), 32'h404);

    // Misc decode
    ctrl("unmapped rd", 1'b0, 1'b1, 20'h14, 32'd0, 32'd0);
    ctrl("wr+rd", 1'b1, 1'b1, 20'h04, 32'hFFFF, 32'd0);
    ctrl("rd active 404", 1'b0, 1'b1, 20'h04, 32'd0, 32'h404);

    // Packet counter
    ctrl("clr cnt", 1'b1, 1'b0, 20'h10, 32'd0, 32'd0);
    send_pkt(1); send_pkt(2); send_pkt(8);
    ctrl("cnt 3", 1'b0, 1'b1, 20'h10, 32'd0, 32'd3);
    ctrl("clr cnt b", 1'b1, 1'b0, 20'h10, 32'd0, 32'd0);
    send_pkt(1); send_pkt(3);
    ctrl("cnt 2", 1'b0, 1'b1, 20'h10, 32'd0, 32'd2);
    tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
    ctrl("clr with tlast", 1'b1, 1'b0, 20'h10, 32'd0, 32'd0);
    idle();
    ctrl("cnt clr wins", 1'b0, 1'b1, 20'h10, 32'd0, 32'd0);

    // Reset mid-packet with a gain pending
    tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    tick();
    ctrl("push 600", 1'b1, 1'b0, 20'h00, 32'h0600, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check_val("rst mid gain", 32'(gain_active), 32'h100);
    check_val("rst mid ack", 32'(resp_ack), 32'd0);
    ctrl("status post rst", 1'b0, 1'b1, 20'h08, 32'd0, 32'd0);
    tick();
    check_val("fifo emptied", 32'(gain_active), 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gain_sched_ctrl.md
# gain_sched_ctrl

Gain update scheduler for the OOT gain block. It sits between the NoC shell's CtrlPort master and the gain datapath, all on the shell's data clock. Host gain writes are queued in a small FIFO. Each queued gain is applied only at a packet boundary of the input payload stream, so every packet is scaled by a single constant gain.

## Interface
- GAIN_W, 16: width of gain word (datapath treats as Q8.8 unsigned)
- DEFAULT_GAIN, 16'h0100: gain_active value after reset (unity)
- FIFO_AW, 2: log2 of pending-gain FIFO depth (depth 4)
- BASE_ADDR, 20'h0: CtrlPort base; registers at BASE_ADDR + {0x00,0x04,0x08,0x0C,0x10}
---
- axis_data_clk  in  1  sole clock
- axis_data_rst  in  1  synchronous, active-high reset
- s_ctrlport_req_wr  in  1  write strobe, single cycle
- s_ctrlport_req_rd  in  1  read strobe, single cycle
- s_ctrlport_req_addr  in  20  byte address
- s_ctrlport_req_data  in  32  write data
- s_ctrlport_resp_ack  out  1  response strobe
- s_ctrlport_resp_data  out  32  read data (0 on writes)
- pkt_tvalid  in  1  observed payload stream valid (monitor only)
- pkt_tready  in  1  observed payload stream ready (monitor only)
- pkt_tlast  in  1  observed payload stream last
- gain_active  out  GAIN_W  gain the datapath applies to the current beat

## Operation
- A beat is accepted when pkt_tvalid & pkt_tready.
- in_pkt register:
  - 0 after reset.
  - Set on an accepted beat with tlast=0.
  - Cleared on an accepted beat with tlast=1.
- Boundary event (pop opportunity) occurs when either:
  - an accepted beat has tlast=1, or
  - in_pkt=0 and no beat is accepted this cycle.
- At a boundary event with the FIFO non-empty: pop the head and load it into gain_active. Otherwise gain_active holds.
- An accepted first beat with tlast=0 while in_pkt=0 is not a boundary. No pop occurs, so the gain in place before that beat covers the whole packet.
- Registers (offset from BASE_ADDR):
  - 0x00 GAIN_PUSH (W): push data[GAIN_W-1:0]. If FIFO full and no pop this cycle: drop the value and set overflow. Reads return 0.
  - 0x04 GAIN_ACTIVE (R): {zero-extend, gain_active}.
  - 0x08 STATUS (R/W1C): [FIFO_AW:0] fill count, [8] overflow sticky, [9] in_pkt. Writing bit8=1 clears overflow.
  - 0x0C CTRL (W): bit0=1 flushes the FIFO (count→0). Reads return 0.
  - 0x10 PKT_COUNT (R/W): 32-bit count of tlast beats, wraps 0xFFFFFFFF→0. Any write clears it to 0.
- Unmapped address: ack with resp_data=0, no side effects.
- req_wr and req_rd asserted together: treated as a write, one ack, resp_data=0.
- Push and pop in the same cycle: both take effect and count is unchanged. A push into a full FIFO is accepted if a pop occurs that cycle.
- Flush and pop in the same cycle: the head is still applied to gain_active, and the FIFO ends empty.
- Overflow set and W1C in the same cycle cannot occur (single request per cycle).
- PKT_COUNT increment coincident with a clear write: result is 0.
- Reset mid-packet:
  - in_pkt→0, FIFO empty, overflow→0, PKT_COUNT→0, gain_active→DEFAULT_GAIN.
  - The remainder of the interrupted packet is treated as a new packet.

## Timing
- Reset values: s_ctrlport_resp_ack=0, s_ctrlport_resp_data=0, gain_active=DEFAULT_GAIN.
- CtrlPort latency: ack asserted exactly 1 cycle after the request, for 1 cycle. resp_data is valid in the ack cycle and 0 otherwise.
- Write effects (push, flush, clear) are registered on the request cycle's edge.
  - A push in cycle N is visible in STATUS and poppable from cycle N+1.
  - Earliest gain_active change from a push is cycle N+2, via a boundary in cycle N+1.
- Pop timing: a boundary in cycle N updates gain_active in cycle N+1. With back-to-back packets (tlast beat at N, next first beat at N+1), beat N+1 uses the new gain.
- No combinational path from pkt_* or the CtrlPort inputs to any output.

## Test plan
- Reset, idle stream; read 0x04 → 0x00000100, ack exactly 1 cycle after rd.
- Idle stream; write 0x00=0x0200 at cycle N → gain_active=0x0200 at N+2; STATUS count returns to 0.
- Mid-packet (in_pkt=1), push 0x0300 → gain_active holds for all remaining beats. It changes to 0x0300 on the cycle after the tlast beat, and the next packet's first back-to-back beat sees 0x0300.
- Continuous packet with tready=0, push 5 gains → count=4, overflow=1. Write 0x08=0x100 → overflow=0. After 4 packets, gain_active equals the 4th pushed value.
- Push 3 gains mid-packet, write 0x0C=1 → count=0; tlast leaves gain_active unchanged.
- 3 packets of 1, 2, 8 beats with random tready → PKT_COUNT=3. Preload 0xFFFFFFFF is impossible, so instead check 2 packets after a clear → 2. Reset mid-packet → gain_active=0x0100, in_pkt=0.
